// File: rtl/tile_io_pkg.sv
// Shared types and constants for the tile I/O responder: FSM state encoding,
// fill byte returned on a timed-out read, and the default ack timeout.
package tile_io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        REQ,
        DRIVE,
        DONE
    } state_t;

    localparam logic [7:0] FILL_BYTE       = 8'hFF;
    localparam int         TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/tile_io_responder_if.sv
// Dock-side bus, local register handshake and error flag of one tile responder.
// The responder uses the slave view; whatever drives the dock and registers uses master.
interface tile_io_responder_if #(
    parameter int ADDR_W = 4
);
    logic              cs_n;
    logic              io_r_w_;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        d_in;
    logic [7:0]        d_out;
    logic              d_oe;
    logic              wait_n;
    logic              reg_req;
    logic              reg_we;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic [7:0]        reg_rdata;
    logic              reg_ack;
    logic              err;
    logic              err_clr;

    modport slave (
        input  cs_n, io_r_w_, addr, d_in, reg_rdata, reg_ack, err_clr,
        output d_out, d_oe, wait_n, reg_req, reg_we, reg_addr, reg_wdata, err
    );

    modport master (
        output cs_n, io_r_w_, addr, d_in, reg_rdata, reg_ack, err_clr,
        input  d_out, d_oe, wait_n, reg_req, reg_we, reg_addr, reg_wdata, err
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to the idle-high level.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= 1'b1;
            ff2_q <= 1'b1;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;
endmodule

// File: rtl/tile_io_responder.sv
// Tile bus responder: turns an asynchronous dock access into a local register
// request, stretches the CPU cycle until ack or timeout, then drives read data.
module tile_io_responder
    import tile_io_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    tile_io_responder_if.slave  bus
);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic cs_s;
    logic rw_s;

    sync_2ff u_sync_cs (.clk(clk), .rst_n(rst_n), .d_i(bus.cs_n),    .q_o(cs_s));
    sync_2ff u_sync_rw (.clk(clk), .rst_n(rst_n), .d_i(bus.io_r_w_), .q_o(rw_s));

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        d_out_q, d_out_d;
    logic [7:0]        reg_wdata_q, reg_wdata_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic              reg_we_q, reg_we_d;
    logic              err_q, err_d;
    logic              abort_q, abort_d;
    logic              timeout;
    logic              aborted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            d_out_q     <= '0;
            reg_wdata_q <= '0;
            reg_addr_q  <= '0;
            reg_we_q    <= 1'b0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            d_out_q     <= d_out_d;
            reg_wdata_q <= reg_wdata_d;
            reg_addr_q  <= reg_addr_d;
            reg_we_q    <= reg_we_d;
            err_q       <= err_d;
            abort_q     <= abort_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        d_out_d     = d_out_q;
        reg_wdata_d = reg_wdata_q;
        reg_addr_d  = reg_addr_q;
        reg_we_d    = reg_we_q;
        abort_d     = abort_q;
        timeout     = 1'b0;
        // A deselect seen any time before completion turns the access into an abort.
        aborted     = abort_q | cs_s;

        case (state_q)
            IDLE: begin
                if (!cs_s) state_d = CAPTURE;
            end
            CAPTURE: begin
                reg_addr_d  = bus.addr;
                reg_wdata_d = bus.d_in;
                reg_we_d    = ~rw_s;
                cnt_d       = '0;
                abort_d     = cs_s;
                state_d     = REQ;
            end
            REQ: begin
                abort_d = aborted;
                if (bus.reg_ack) begin
                    if (!reg_we_q) d_out_d = bus.reg_rdata;
                    state_d = aborted ? DONE : DRIVE;
                end else if (cnt_q == TIMEOUT_C) begin
                    d_out_d = FILL_BYTE;
                    timeout = 1'b1;
                    state_d = aborted ? DONE : DRIVE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DRIVE: begin
                if (cs_s) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timeout set wins over a simultaneous clear.
        if (timeout)          err_d = 1'b1;
        else if (bus.err_clr) err_d = 1'b0;
        else                  err_d = err_q;
    end

    assign bus.reg_req   = (state_q == REQ);
    assign bus.wait_n    = !((state_q == CAPTURE) || (state_q == REQ));
    assign bus.d_oe      = (state_q == DRIVE) && !reg_we_q && !cs_s;
    assign bus.d_out     = d_out_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_tile_io_responder.sv
// Randomized bench for tile_io_responder: a register-side responder with a
// programmable ack delay, plus an access-level model of d_out, err and timing.
module tb_tile_io_responder;
    localparam int TIMEOUT = 8;
    localparam int NO_ACK  = 99;

    logic clk;
    logic rst_n;
    logic tb_clr;
    logic rsp_clr;

    tile_io_responder_if #(.ADDR_W(4)) bus ();

    tile_io_responder #(.ADDR_W(4), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.err_clr = tb_clr | rsp_clr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cur_delay = NO_ACK;
    logic [7:0] cur_rdata = 8'h00;
    bit         clr_at_to = 1'b0;
    logic [7:0] dout_exp  = 8'h00;
    logic       err_exp   = 1'b0;
    int         txn_no    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] out_vec();
        return {bus.wait_n, bus.d_oe, bus.d_out, bus.reg_req, bus.reg_we,
                bus.reg_addr, bus.reg_wdata, bus.err};
    endfunction

    // Register side: acks in the REQ cycle numbered cur_delay (0 = first),
    // and after a timeout sends one late ack that must be ignored.
    initial begin
        int  k;
        bit  late_pending;
        k = 0;
        late_pending = 1'b0;
        bus.reg_ack   = 1'b0;
        bus.reg_rdata = 8'h00;
        rsp_clr       = 1'b0;
        forever begin
            @(negedge clk);
            bus.reg_ack   = 1'b0;
            bus.reg_rdata = 8'($urandom);
            rsp_clr       = 1'b0;
            if (!rst_n) begin
                k = 0;
                late_pending = 1'b0;
            end else if (bus.reg_req) begin
                if (k == cur_delay) begin
                    bus.reg_ack   = 1'b1;
                    bus.reg_rdata = cur_rdata;
                end
                if (k == TIMEOUT && clr_at_to) rsp_clr = 1'b1;
                k++;
                late_pending = (cur_delay > TIMEOUT);
            end else begin
                k = 0;
                if (late_pending) begin
                    bus.reg_ack  = 1'b1;
                    late_pending = 1'b0;
                end
            end
        end
    end

    task automatic do_access(input logic rw, input logic [3:0] a, input logic [7:0] wd,
                             input logic [7:0] rd, input int dly, input bit abort,
                             input bit clr_to, input bit rst_mid);
        int t;
        int wlow;
        int n;
        int hold;
        bit timed;
        timed     = (dly > TIMEOUT);
        cur_delay = dly;
        cur_rdata = rd;
        clr_at_to = clr_to;
        bus.io_r_w_ = rw;
        bus.addr    = a;
        bus.d_in    = wd;
        bus.cs_n    = 1'b0;

        t = 0;
        wlow = -1;
        while (!bus.reg_req && t < 8) begin
            @(negedge clk);
            t++;
            if (!bus.wait_n && wlow < 0) wlow = t;
            if (!bus.reg_req) chk("d_oe_capture", bus.d_oe, 1'b0);
        end
        chk("req_seen", bus.reg_req, 1'b1);
        chk("wait_low_by3", 32'(wlow >= 1 && wlow <= 3), 32'd1);

        n = 0;
        while (bus.reg_req && n < 2 * TIMEOUT + 8) begin
            chk("req_hold", {bus.reg_we, bus.reg_addr, bus.reg_wdata, bus.wait_n, bus.d_oe},
                {~rw, a, wd, 1'b0, 1'b0});
            if (abort && n == 1) bus.cs_n = 1'b1;
            n++;
            @(negedge clk);
        end
        chk("req_cycles", n, timed ? TIMEOUT + 1 : dly + 1);

        if (timed) begin
            dout_exp = 8'hFF;
            err_exp  = 1'b1;
        end else if (rw) begin
            dout_exp = rd;
        end
        chk("d_out", bus.d_out, dout_exp);
        chk("err", bus.err, err_exp);
        chk("wait_n_release", bus.wait_n, 1'b1);

        if (rst_mid) begin
            chk("d_oe_before_rst", bus.d_oe, rw);
            #2 rst_n = 1'b0;
            #1 chk("async_reset", out_vec(), {1'b1, 24'h0});
            @(negedge clk);
            chk("reset_held", out_vec(), {1'b1, 24'h0});
            bus.cs_n = 1'b1;
            rst_n    = 1'b1;
            dout_exp = 8'h00;
            err_exp  = 1'b0;
            repeat (3) @(negedge clk);
        end else if (!abort) begin
            hold = $urandom_range(0, 3);
            for (int i = 0; i <= hold; i++) begin
                chk("d_oe_drive", bus.d_oe, rw);
                if (i < hold) @(negedge clk);
            end
            bus.cs_n = 1'b1;
            @(negedge clk);
            chk("d_oe_sync_lag", bus.d_oe, rw);
            @(negedge clk);
            chk("d_oe_release", bus.d_oe, 1'b0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("tail", {bus.d_oe, bus.reg_req, bus.wait_n}, 3'b001);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                chk("abort_tail", {bus.d_oe, bus.reg_req, bus.wait_n}, 3'b001);
                @(negedge clk);
            end
        end
        chk("d_out_idle", bus.d_out, dout_exp);
        $display("[TB] txn %0d rw=%0d addr=%h wd=%h rd=%h dly=%0d abort=%0d rst=%0d req_cycles=%0d d_out=%h err=%0d",
                 txn_no, rw, a, wd, rd, dly, abort, rst_mid, n, bus.d_out, bus.err);
        txn_no++;
    endtask

    task automatic clear_err();
        @(negedge clk);
        tb_clr = 1'b1;
        @(negedge clk);
        tb_clr  = 1'b0;
        err_exp = 1'b0;
        chk("err_clr", bus.err, err_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rw;
        bit   ab;
        int   dly;
        rst_n       = 1'b0;
        tb_clr      = 1'b0;
        bus.cs_n    = 1'b1;
        bus.io_r_w_ = 1'b1;
        bus.addr    = 4'h0;
        bus.d_in    = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_state", out_vec(), {1'b1, 24'h0});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_access(1'b0, 4'h3, 8'hA5, 8'h00, 4,       1'b0, 1'b0, 1'b0);
        do_access(1'b1, 4'h7, 8'h00, 8'h5C, 2,       1'b0, 1'b0, 1'b0);
        do_access(1'b1, 4'h1, 8'h11, 8'h22, NO_ACK,  1'b0, 1'b0, 1'b0);
        clear_err();
        do_access(1'b1, 4'h9, 8'h00, 8'h3C, TIMEOUT, 1'b0, 1'b0, 1'b0);
        do_access(1'b0, 4'h4, 8'h44, 8'h00, NO_ACK,  1'b0, 1'b1, 1'b0);
        do_access(1'b0, 4'h2, 8'h6E, 8'h00, 5,       1'b1, 1'b0, 1'b0);
        do_access(1'b1, 4'h6, 8'h00, 8'h81, 1,       1'b0, 1'b0, 1'b1);
        do_access(1'b0, 4'hF, 8'h0F, 8'h00, 0,       1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rw  = 1'($urandom);
            ab  = ($urandom_range(0, 4) == 0);
            dly = ab ? $urandom_range(3, TIMEOUT + 2) : $urandom_range(0, TIMEOUT + 2);
            do_access(rw, 4'($urandom), 8'($urandom), 8'($urandom), dly, ab,
                      (dly > TIMEOUT) && 1'($urandom), 1'b0);
            if ($urandom_range(0, 3) == 0) clear_err();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tile_io_responder.md
TILE_IO_RESPONDER -- requirements
Module: tile_io_responder

Interface
REQ-001 Parameter ADDR_W, default 4, width of the tile-local register address captured from the bus.
REQ-002 Parameter TIMEOUT, default 255, the maximum number of clocks to wait for reg_ack before forcing a fill response (valid range 1..255).
REQ-003 clk  input  1  tile clock; single clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cs_n  input  1  dock window select for this tile, active low, asynchronous to clk.
REQ-006 io_r_w_  input  1  qualified CPU direction from dock: 1 = read, 0 = write; asynchronous.
REQ-007 addr  input  ADDR_W  bus address low bits; stable while cs_n is low.
REQ-008 d_in  input  8  bus write data; stable while cs_n is low.
REQ-009 d_out  output  8  read data toward the bus.
REQ-010 d_oe  output  1  1 = tile drives the data bus.
REQ-011 wait_n  output  1  0 = stretch the CPU cycle.
REQ-012 reg_req, reg_we  output  1 each  local register request and its write enable.
REQ-013 reg_addr  output  ADDR_W;  reg_wdata  output  8  captured address and write data.
REQ-014 reg_rdata  input  8;  reg_ack  input  1  local read data and request completion.
REQ-015 err  output  1  sticky timeout flag.
REQ-016 err_clr  input  1  clears err.

Function
REQ-017 cs_n and io_r_w_ SHALL each pass through a 2-flop synchronizer; every FSM decision uses the synchronized values (cs_s, rw_s).
REQ-018 The FSM SHALL have the states IDLE, CAPTURE, REQ, DRIVE, DONE.
REQ-019 IDLE -> CAPTURE SHALL occur on the first clock with cs_s = 0.
REQ-020 wait_n SHALL be 0 from CAPTURE through REQ and 1 in every other state; it goes low no later than 3 clocks after cs_n falls.
REQ-021 CAPTURE SHALL latch addr, d_in and rw_s into reg_addr, reg_wdata and reg_we = ~rw_s, then move to REQ on the next clock.
REQ-022 In REQ, reg_req SHALL be 1 and the address, write data and reg_we it presents SHALL stay constant until reg_ack is sampled 1.
REQ-023 On reg_ack in REQ:
- for a read, d_out SHALL load reg_rdata;
- the FSM SHALL go to DRIVE;
- reg_req SHALL be 0 on the following clock.
REQ-024 An 8-bit counter SHALL clear on entry to REQ and increment each clock in REQ; when it equals TIMEOUT with no ack:
- d_out SHALL load 8'hFF;
- err SHALL set;
- the FSM SHALL go to DRIVE.
REQ-025 When reg_ack = 1 and the timeout are true in the same clock, the ack SHALL take priority and err SHALL NOT set.
REQ-026 After a timeout, reg_req SHALL drop; a reg_ack arriving later while the FSM is in DRIVE, DONE or IDLE SHALL be ignored.
REQ-027 In DRIVE, d_oe SHALL be 1 only for read cycles; the FSM SHALL stay in DRIVE while cs_s = 0.
REQ-028 DRIVE -> DONE SHALL occur on cs_s = 1, and d_oe SHALL go to 0 in that same clock (d_oe is combinational from state and cs_s).
REQ-029 DONE -> IDLE SHALL occur unconditionally after one clock; this guarantees a one-clock gap between accesses.
REQ-030 If cs_s returns to 1 while the FSM is in CAPTURE or REQ (aborted access):
- the REQ handshake SHALL still complete, by ack or by timeout;
- the FSM SHALL then go straight to DONE;
- d_oe SHALL never assert.
REQ-031 cs_n low pulses shorter than 2 clocks are not guaranteed to be detected; a detected pulse SHALL complete the full sequence.
REQ-032 err_clr SHALL clear err; when err_clr and a timeout occur in the same clock, the set SHALL win.

Reset
REQ-033 While rst_n = 0, the block SHALL hold:
- state = IDLE;
- wait_n = 1;
- d_oe = 0, d_out = 8'h00;
- reg_req = 0, reg_we = 0, reg_addr = 0, reg_wdata = 0;
- err = 0;
- counter = 0;
- synchronizer flops = 1.
REQ-034 Reset asserted mid-access SHALL abandon the access immediately; the first cs_s = 0 after reset SHALL start a new access.

Structure
REQ-035 Package tile_io_pkg SHALL hold the state enum, FILL_BYTE = 8'hFF and the default TIMEOUT.
REQ-036 The synchronizer SHALL be a separate sub-module, sync_2ff, instantiated twice.

Verification
REQ-037 Write: cs_n low, io_r_w_ = 0, addr = 4'h3, d_in = 8'hA5, ack after 4 clocks -> exactly one reg_req with reg_we = 1, reg_addr = 3, reg_wdata = A5; wait_n low until the ack; d_oe stays 0.
REQ-038 Read: addr = 4'h7, reg_rdata = 8'h5C, ack after 2 clocks -> d_out = 5C; d_oe = 1 until cs_n rises, then 0 in the same clock cs_s goes 1.
REQ-039 Timeout with TIMEOUT = 8 and no ack -> d_out = FF and err = 1 at counter 8; wait_n releases; a late ack causes no state change.
REQ-040 Abort: cs_n high 1 clock after entering REQ, ack after 5 clocks -> reg_req held until the ack; d_oe stays 0; IDLE reached via DONE.
REQ-041 Reset asserted in DRIVE -> all outputs at their reset values asynchronously; the next access completes normally.
